nmi_spad_resp: RTL and testbench

//  Responder (slave) end of the native memory interface (nmi_if) driven by user cores.

---
 rtl/nmi_spad_pkg.sv | 19 +
 rtl/nmi_spad_ram.sv | 35 +++
 rtl/nmi_spad_resp.sv | 133 +++++++++++++
 tb/tb_nmi_spad_resp.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/nmi_spad_pkg.sv
// Shared types and constants for the nmi scratchpad responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package nmi_spad_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Returned on reads that miss the decode window.
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  // Width of the wait-state counter (WAIT_CYC is 0..15).
  localparam int WAIT_W = 4;

endpackage

// File: rtl/nmi_spad_ram.sv
// Single-port behavioural SRAM, DEPTH x 32, per-byte write enables.
// Latency: read data on q one cycle after en; q holds the last read value.
// Backpressure: none, one access per enabled cycle; replaced by an SRAM macro at integration.
module spad_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   q_o
);

  logic [31:0] mem [DEPTH];
  logic [31:0] q_q;

  // Byte-masked write or registered read; a write leaves q untouched.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end else begin
        q_q <= mem[addr_i];
      end
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/nmi_spad_resp.sv
// nmi slave: decodes one window onto an SRAM scratchpad; optional error counter under NMI_SPAD_ERRCNT_EN.
// Latency: valid sampled in cycle N -> single-cycle ready in cycle N+2+WAIT_CYC, reads and writes alike.
// Backpressure: master holds valid/addr/wdata/wstrb until ready; one transaction in flight, no queuing.
module nmi_spad_resp
  import nmi_spad_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          DEPTH     = 1024,
  parameter int          WAIT_CYC  = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        nmi_valid_i,
  output logic        nmi_ready_o,
  input  logic [31:0] nmi_addr_i,
  input  logic [31:0] nmi_wdata_i,
  input  logic [3:0]  nmi_wstrb_i,
  output logic [31:0] nmi_rdata_o,
  output logic        hit_o,
  output logic [15:0] err_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(WAIT_CYC);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]     addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wstrb_q;
  logic              hit_q;
  logic              ram_en;
  logic [31:0]       ram_q;

  // Byte offset is ignored: every access is a full word.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^nmi_addr_i[1:0];

  // Window is aligned to DEPTH*4, so the upper address bits alone decide a hit.
  assign hit_o = (nmi_addr_i[31:AW+2] == BASE_ADDR[31:AW+2]);

  // FSM state and wait counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request when it is accepted in IDLE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      hit_q   <= 1'b0;
    end else if (state_q == IDLE && nmi_valid_i) begin
      addr_q  <= nmi_addr_i[AW+1:2];
      wdata_q <= nmi_wdata_i;
      wstrb_q <= nmi_wstrb_i;
      hit_q   <= hit_o;
    end
  end

  // Next state, RAM strobe and response outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_en      = 1'b0;
    nmi_ready_o = 1'b0;
    nmi_rdata_o = 32'h0;
    case (state_q)
      IDLE: begin
        if (nmi_valid_i) state_d = ACCESS;
      end
      ACCESS: begin
        ram_en  = hit_q;
        cnt_d   = WAIT_LD;
        state_d = (WAIT_CYC == 0) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) state_d = RESP;
      end
      RESP: begin
        nmi_ready_o = 1'b1;
        if (!hit_q)          nmi_rdata_o = ERR_RDATA;
        else if (~|wstrb_q)  nmi_rdata_o = ram_q;
        else                 nmi_rdata_o = 32'h0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset masks the strobe so a write caught mid-access never lands.
  spad_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .en_i    (ram_en & ~rst_i),
    .we_i    (|wstrb_q),
    .be_i    (wstrb_q),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .q_o     (ram_q)
  );

`ifdef NMI_SPAD_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Count out-of-window responses, sticking at all-ones.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (state_q == RESP && !hit_q && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  // Error counter register, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_nmi_spad_resp.sv
// Bench for nmi_spad_resp: two instances (WAIT_CYC 0 and 3), scoreboard-checked.
// Latency: checks ready lands exactly at N+2+WAIT_CYC.
// Backpressure: master holds the request until ready, drops valid on the sampling edge.
module tb_nmi_spad_resp;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          DEP  = 1024;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
`ifdef NMI_SPAD_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic        rdy   [2];
  logic [31:0] rdata [2];
  logic        hit   [2];
  logic [15:0] errc  [2];

  int  tests = 0;
  int  fails = 0;
  int  cyc   = 0;
  bit  mon_en = 1'b0;
  exp_t sb0[$];
  exp_t sb1[$];
  logic [31:0] mdl [2][DEP];
  int  err_m [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nmi_spad_resp #(.BASE_ADDR(BASE), .DEPTH(DEP), .WAIT_CYC(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .nmi_valid_i(vld[0]), .nmi_ready_o(rdy[0]),
    .nmi_addr_i(addr[0]), .nmi_wdata_i(wdata[0]), .nmi_wstrb_i(wstrb[0]),
    .nmi_rdata_o(rdata[0]), .hit_o(hit[0]), .err_cnt_o(errc[0]));

  nmi_spad_resp #(.BASE_ADDR(BASE), .DEPTH(DEP), .WAIT_CYC(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .nmi_valid_i(vld[1]), .nmi_ready_o(rdy[1]),
    .nmi_addr_i(addr[1]), .nmi_wdata_i(wdata[1]), .nmi_wstrb_i(wstrb[1]),
    .nmi_rdata_o(rdata[1]), .hit_o(hit[1]), .err_cnt_o(errc[1]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit in_win(input logic [31:0] a);
    longint ua = longint'({32'h0, a});
    longint ub = longint'({32'h0, BASE});
    return (ua >= ub) && (ua < ub + 4 * DEP);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // One complete master transaction on instance d, with model update and scoreboard push.
  task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    exp_t e;
    int   w = (d == 0) ? 0 : 3;
    int   idx;
    bit   got = 1'b0;
    @(posedge clk); #1;
    vld[d] = 1'b1; addr[d] = a; wdata[d] = wd; wstrb[d] = ws;
    #1;
    chk($sformatf("hit%0d[%h]", d, a), {31'h0, hit[d]}, {31'h0, in_win(a)});
    if (in_win(a)) begin
      idx = int'((a - BASE) >> 2);
      if (ws == 4'h0) e.dat = mdl[d][idx];
      else begin
        mdl[d][idx] = merge(mdl[d][idx], wd, ws);
        e.dat = 32'h0;
      end
    end else begin
      e.dat = ERRD;
      if (CNT_EN && err_m[d] < 65535) err_m[d]++;
    end
    e.cyc = cyc + 2 + w;
    if (d == 0) sb0.push_back(e); else sb1.push_back(e);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rdy[d] === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    vld[d] = 1'b0;
    if (!got) begin
      tests++; fails++;
      $display("FAIL timeout%0d[%h]: got no ready, expected ready within 40 cycles", d, a);
      if (d == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
    end
    chk($sformatf("err_cnt%0d", d), {16'h0, errc[d]}, 32'(err_m[d]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    err_m[0] = 0; err_m[1] = 0;
  endtask

  // Monitor: every ready pops the scoreboard; outside ready rdata must be zero.
  task automatic mon_port(input int d);
    exp_t e;
    if (rdy[d] === 1'b1) begin
      if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
        tests++; fails++;
        $display("FAIL unexp_ready%0d: got ready at cycle %0d, expected none", d, cyc);
      end else begin
        if (d == 0) e = sb0.pop_front(); else e = sb1.pop_front();
        chk($sformatf("rdata%0d", d), rdata[d], e.dat);
        chk($sformatf("ready_cyc%0d", d), 32'(cyc), 32'(e.cyc));
      end
    end else begin
      chk($sformatf("idle_rdata%0d", d), rdata[d], 32'h0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_port(0);
      mon_port(1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, wd;
    logic [3:0]  ws;
    int          d, idx;
    for (int k = 0; k < 2; k++) begin
      vld[k] = 1'b0; addr[k] = '0; wdata[k] = '0; wstrb[k] = '0;
    end
    do_reset();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ready%0d", k), {31'h0, rdy[k]}, 32'h0);
      chk($sformatf("rst_rdata%0d", k), rdata[k], 32'h0);
      chk($sformatf("rst_err%0d", k), {16'h0, errc[k]}, 32'h0);
    end
    mon_en = 1'b1;

    for (int k = 0; k < 2; k++) begin
      // Known contents for the first 64 words and the last word.
      for (int i = 0; i < 64; i++) txn(k, BASE + 32'(4 * i), $urandom, 4'hF);
      txn(k, BASE + 32'(4 * DEP - 4), 32'hCAFE_F00D, 4'hF);
      // Full write then read-back of the same word.
      txn(k, 32'h3000_0010, 32'h1234_5678, 4'hF);
      txn(k, 32'h3000_0010, 32'h0, 4'h0);
      // Byte strobes leave unselected bytes alone.
      txn(k, 32'h3000_0020, 32'hAABB_CCDD, 4'hF);
      txn(k, 32'h3000_0020, 32'h0000_0011, 4'b0101);
      txn(k, 32'h3000_0020, 32'h0, 4'h0);
      chk($sformatf("bytemask_model%0d", k), mdl[k][8], 32'hAA00_CC11);
      // Out-of-window read and write; the aliased in-window word is untouched.
      txn(k, 32'h4000_0000, 32'h0, 4'h0);
      txn(k, 32'h4000_0010, 32'h5555_AAAA, 4'hF);
      txn(k, 32'h3000_0010, 32'h0, 4'h0);
      // Window edges and byte-offset alias.
      txn(k, BASE + 32'(4 * DEP - 4), 32'h0BAD_1DEA, 4'hF);
      txn(k, BASE + 32'(4 * DEP - 4), 32'h0, 4'h0);
      txn(k, BASE + 32'(4 * DEP), 32'h0, 4'h0);
      txn(k, BASE - 32'd4, 32'h0, 4'h0);
      txn(k, 32'h3000_0013, 32'h0, 4'h0);
    end

    // Randomised mix over both instances.
    for (int i = 0; i < 200; i++) begin
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 9) < 8) begin
        idx = int'($urandom_range(0, 63));
        a   = BASE + 32'(4 * idx) + 32'($urandom_range(0, 3));
      end else begin
        a = $urandom;
        if (in_win(a)) a = a ^ 32'h8000_0000;
      end
      wd = $urandom;
      ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      txn(d, a, wd, ws);
    end

    // Reset lands while a write sits in ACCESS: no ready, no write, clean restart.
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      vld[k] = 1'b1; addr[k] = 32'h3000_0014; wdata[k] = 32'hFFFF_FFFF; wstrb[k] = 4'hF;
      @(posedge clk); #1;
      rst = 1'b1; vld[k] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      err_m[0] = 0; err_m[1] = 0;
      chk($sformatf("postrst_err%0d", k), {16'h0, errc[k]}, 32'h0);
      txn(k, 32'h3000_0014, 32'h0, 4'h0);
      txn(k, 32'h5000_0000, 32'h0, 4'h0);
    end

    repeat (8) @(posedge clk);
    chk("sb0_empty", 32'(sb0.size()), 32'h0);
    chk("sb1_empty", 32'(sb1.size()), 32'h0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
